// File: rtl/divisor_sat.sv
// Sequential saturating signed divider: restoring division, one quotient bit per clock,
// with clamping of overflow and divide-by-zero results to the representable range.
`timescale 1ns/1ps
module divisor_sat #(
  parameter int size = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic signed [size-1:0] A,
  input  logic signed [size-1:0] B,
  output logic                   busy,
  output logic                   done,
  output logic signed [size-1:0] Div,
  output logic signed [size-1:0] Rem,
  output logic                   dz,
  output logic                   sat
);

  // state | meaning
  // IDLE  | waiting for start; result registers hold the last answer
  // CALC  | one restoring step per clock, MSB first
  // FIX   | apply signs/saturation, register result, pulse done
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = $clog2(size + 1);
  localparam logic [size-1:0] MAXV = {1'b0, {(size-1){1'b1}}};
  localparam logic [size-1:0] MINV = {1'b1, {(size-1){1'b0}}};

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [size-1:0] dvd, bmag, quo, rem_r;
  logic            qsign, rsign, a_zero, b_zero;

  logic [size-1:0] amag_in, bmag_in, rem_step;
  logic [size:0]   trial;
  logic            ge;
  logic [size-1:0] div_fix, rem_fix;
  logic            dz_fix, sat_fix;

  assign amag_in = A[size-1] ? (~A + 1'b1) : A;
  assign bmag_in = B[size-1] ? (~B + 1'b1) : B;
  assign trial   = {rem_r, dvd[size-1]};
  assign ge      = trial >= {1'b0, bmag};
  assign rem_step = ge ? (trial[size-1:0] - bmag) : trial[size-1:0];
  assign busy    = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == CW'(1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    div_fix = qsign ? (~quo + 1'b1) : quo;
    rem_fix = rsign ? (~rem_r + 1'b1) : rem_r;
    dz_fix  = 1'b0;
    sat_fix = 1'b0;
    if (b_zero) begin
      dz_fix  = 1'b1;
      rem_fix = '0;
      if (a_zero) begin
        div_fix = '0;
      end else begin
        div_fix = rsign ? MINV : MAXV;
        sat_fix = 1'b1;
      end
    end else if (!qsign && (quo > MAXV)) begin
      // only min / -1 lands here
      div_fix = MAXV;
      rem_fix = '0;
      sat_fix = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      bmag   <= '0;
      quo    <= '0;
      rem_r  <= '0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      a_zero <= 1'b0;
      b_zero <= 1'b0;
      done   <= 1'b0;
      Div    <= '0;
      Rem    <= '0;
      dz     <= 1'b0;
      sat    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvd    <= amag_in;
          bmag   <= bmag_in;
          quo    <= '0;
          rem_r  <= '0;
          qsign  <= A[size-1] ^ B[size-1];
          rsign  <= A[size-1];
          a_zero <= (A == '0);
          b_zero <= (B == '0);
          cnt    <= CW'(size);
        end
        CALC: begin
          rem_r <= rem_step;
          quo   <= {quo[size-2:0], ge};
          dvd   <= {dvd[size-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          Div  <= div_fix;
          Rem  <= rem_fix;
          dz   <= dz_fix;
          sat  <= sat_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
